// File: rtl/seq_serializer.sv
// seq_serializer: parallel word in via valid/ready, MSB-first serial stream out with programmable inter-bit gap
module seq_serializer #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [GAP_W-1:0] load_gap,
    output logic             load_rdy,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic             load_rdy_q, load_rdy_d;
    logic             dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] idx_ld;
    logic [LEN_W-1:0] idx_sel;
    logic             in_bit;
    logic             q_bit;

    // Out-of-range lengths collapse to a full word; the first bit sent sits at len-1
    assign idx_ld  = ((load_len == '0) || (load_len > LEN_MAX)) ? LEN_MAX - LEN_W'(1) : load_len - LEN_W'(1);
    // Outputs are registered, so the bit selected is the one that will be on the wire next cycle
    assign idx_sel = (state_q == SEND) ? idx_q - LEN_W'(1) : idx_q;
    assign in_bit  = |(load_data & (WIDTH'(1) << idx_ld));
    assign q_bit   = |(data_q & (WIDTH'(1) << idx_sel));

    assign load_rdy = load_rdy_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Next-state and next-output logic for the IDLE/SEND/GAP sequencer
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        load_rdy_d = 1'b0;
        dout_d     = 1'b0;
        dout_vld_d = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_vld) begin
                    state_d    = SEND;
                    data_d     = load_data;
                    idx_d      = idx_ld;
                    gap_d      = load_gap;
                    dout_vld_d = 1'b1;
                    dout_d     = in_bit;
                end else begin
                    load_rdy_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            SEND: begin
                if (idx_q == '0) begin
                    state_d    = IDLE;
                    load_rdy_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    idx_d = idx_q - LEN_W'(1);
                    if (gap_q == '0) begin
                        dout_vld_d = 1'b1;
                        dout_d     = q_bit;
                    end else begin
                        cnt_d   = gap_q;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_W'(1)) begin
                    state_d    = SEND;
                    dout_vld_d = 1'b1;
                    dout_d     = q_bit;
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                data_d     = '0;
                idx_d      = '0;
                gap_d      = '0;
                cnt_d      = '0;
                load_rdy_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            cnt_q      <= '0;
            load_rdy_q <= 1'b1;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            load_rdy_q <= load_rdy_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule
